// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared types and helpers for the rca_seq wide-add controller
//
// Purpose : FSM state encoding and the slice-index width helper used by rca_seq.
// Ports   : none (package).
// Config  : RCA_SEQ_SUB_EN is consumed by rca_seq, not by this package.

package rca_seq_pkg;

   // Encodings kept as plain constants so legacy code can compare raw state bits.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } rca_seq_state_t;

   // Slice index width: $clog2(K) bits, but never zero so K=1 still has a register.
   function automatic int idx_width(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/rca.sv
// rtl/rca.sv - N-bit ripple-carry adder shared by the slice sequencer
//
// Purpose : purely combinational N-bit ripple-carry add, sum = a + b + cin.
// Ports   : a, b [N-1:0] operands; cin carry in;
//           sum [N-1:0] result; cout carry out of bit N-1.

module rca #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < N; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[N];

endmodule

// File: rtl/rca_seq.sv
// rtl/rca_seq.sv - multi-cycle N*K-bit adder sequencing one N-bit rca over K slices
//
// Purpose : accepts an N*K-bit add over a valid/ready handshake, runs the K
//           slices LSB first through a single rca instance (carry held in a
//           register between slices) and presents the registered result.
// Config  : define RCA_SEQ_SUB_EN to add the sub port (A - B, cout=1 = no borrow).
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           in_valid/in_ready   operation handshake (ready only in IDLE)
//           a, b [W-1:0], cin   operands, sampled on accept
//           sub                 subtract request (RCA_SEQ_SUB_EN only)
//           out_valid/out_ready result handshake (valid only in DONE)
//           sum [W-1:0], cout, ovf  registered result, carry out, signed overflow

module rca_seq
   import rca_seq_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*K-1:0] a,
   input  logic [N*K-1:0] b,
   input  logic           cin,
`ifdef RCA_SEQ_SUB_EN
   input  logic           sub,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*K-1:0] sum,
   output logic           cout,
   output logic           ovf
);

   localparam int W  = N * K;
   localparam int IW = idx_width(K);

   rca_seq_state_t state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           carry_q, carry_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           cout_q, cout_d;
   logic           ovf_q, ovf_d;
`ifdef RCA_SEQ_SUB_EN
   logic           sub_q, sub_d;
`endif

   logic [N-1:0]   a_sl;
   logic [N-1:0]   b_sl;
   logic [N-1:0]   beff_sl;
   logic [N-1:0]   rca_sum;
   logic           rca_cout;
   logic           last_slice;

   // Slice mux: the only logic in front of the carry chain, so the critical
   // path stays one N-bit ripple regardless of K.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int k = 0; k < K; k++) begin
         if (idx_q == IW'(k)) begin
            a_sl = a_q[k*N +: N];
            b_sl = b_q[k*N +: N];
         end
      end
   end

`ifdef RCA_SEQ_SUB_EN
   assign beff_sl = sub_q ? ~b_sl : b_sl;
`else
   assign beff_sl = b_sl;
`endif

   assign last_slice = (idx_q == IW'(K - 1));

   rca #(.N(N)) u_rca (
      .a    (a_sl),
      .b    (beff_sl),
      .cin  (carry_q),
      .sum  (rca_sum),
      .cout (rca_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
`ifdef RCA_SEQ_SUB_EN
      sub_d   = sub_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               idx_d   = '0;
`ifdef RCA_SEQ_SUB_EN
               sub_d   = sub;
               // Two's-complement subtract: ~B plus a forced carry of one.
               carry_d = sub ? 1'b1 : cin;
`else
               carry_d = cin;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < K; k++) begin
               if (idx_q == IW'(k)) begin
                  sum_d[k*N +: N] = rca_sum;
               end
            end
            carry_d = rca_cout;
            if (last_slice) begin
               cout_d  = rca_cout;
               // Carry into the MSB (a^b^s at that bit) XOR carry out of it.
               ovf_d   = a_sl[N-1] ^ beff_sl[N-1] ^ rca_sum[N-1] ^ rca_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
`ifdef RCA_SEQ_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq.sv
// tb/tb_rca_seq.sv - self-checking bench for rca_seq (N=8, K=4; RCA_SEQ_SUB_EN optional)

module tb_rca_seq;

   localparam int N = 8;
   localparam int K = 4;
   localparam int W = N * K;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rca_seq #(.N(N), .K(K)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef RCA_SEQ_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   typedef struct {
      string        nm;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: plain W+1-bit arithmetic; overflow from operand/result signs.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
      logic [W-1:0] be;
      logic         ci;
      logic [W:0]   r;
      logic         o;
      logic         s_en;
`ifdef RCA_SEQ_SUB_EN
      s_en = ms;
`else
      s_en = 1'b0 & ms;
`endif
      be = s_en ? ~mb : mb;
      ci = s_en ? 1'b1 : mc;
      r  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ci};
      o  = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
      return {o, r};
   endfunction

   task automatic wait_done(input string nm, output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, "_lat"}, 64'(lat), 64'(K));
   endtask

   task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic ts,
                         input logic [W-1:0] es, input logic eco, input logic eov);
      int lat;
      @(negedge clk);
      chk({nm, "_rdy"}, 64'(in_ready), 64'd1);
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done(nm, lat);
      chk({nm, "_sum"}, 64'(sum), 64'(es));
      chk({nm, "_cout"}, 64'(cout), 64'(eco));
      chk({nm, "_ovf"}, 64'(ovf), 64'(eov));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, "_hs"}, 64'({out_valid, in_ready}), 64'b01);
   endtask

   initial begin
      logic [W+1:0] m;
      logic [W-1:0] held;
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           lat;
      int           seen;

      vecs.push_back('{"ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
      vecs.push_back('{"sovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
      vecs.push_back('{"cin",     32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0});
      vecs.push_back('{"negovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
      vecs.push_back('{"allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
      vecs.push_back('{"zero",    32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
`ifdef RCA_SEQ_SUB_EN
      vecs.push_back('{"sub57",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
      vecs.push_back('{"sub75",   32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0});
      vecs.push_back('{"subovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
`endif

      // Reset state
      #2;
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_flags", 64'({cout, ovf, out_valid, in_ready}), 64'b0001);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                vecs[i].s, vecs[i].co, vecs[i].ov);
      end

      // Random operations against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         m  = model(ra, rb, rc, rs);
         run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, m[W-1:0], m[W], m[W+1]);
      end

      // Backpressure: result held in DONE, a pending request waits for the handshake
      @(negedge clk);
      a = 32'h1234_0000; b = 32'h0000_ABCD; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done("bp1", lat);
      chk("bp1_sum", 64'(sum), 64'h1234_ABCD);
      held = sum;
      a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold%0d", i), 64'({sum, cout, out_valid, in_ready}),
             64'({held, 1'b0, 1'b1, 1'b0}));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_after_hs", 64'({out_valid, in_ready}), 64'b01);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_accept", 64'(in_ready), 64'd0);
      wait_done("bp2", lat);
      chk("bp2_sum", 64'(sum), 64'h1010_1010);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Reset during the second RUN cycle aborts the operation
      @(negedge clk);
      a = 32'hDEAD_BEEF; b = 32'h0000_1111; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rrst_sum", 64'(sum), 64'd0);
      chk("rrst_flags", 64'({cout, ovf, out_valid, in_ready}), 64'b0001);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("rrst_no_valid", 64'(seen), 64'd0);
      m = model(32'hCAFE_F00D, 32'h1357_9BDF, 1'b1, 1'b0);
      run_op("after_rst", 32'hCAFE_F00D, 32'h1357_9BDF, 1'b1, 1'b0, m[W-1:0], m[W], m[W+1]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
